shift_scheduler: RTL
====================

SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

Interface
REQ-001 Parameter WIDTH, default 6, is the frame length in bits and the width of each requester data word.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has a word to send.
REQ-005 req0_data  input  WIDTH  requester 0 parallel word.
REQ-006 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 has a word to send.
REQ-008 req1_data  input  WIDTH  requester 1 parallel word.
REQ-009 req1_ready  output  1  requester 1 word accepted this cycle.
REQ-010 sout  output  1  serial data out, LSB first.
REQ-011 sout_valid  output  1  sout carries a frame bit this cycle.
REQ-012 frame_start  output  1  first bit of a frame on sout this cycle.
REQ-013 grant_id  output  1  requester owning the current or most recent frame.
REQ-014 busy  output  1  frame in progress (state SHIFT).

Function
REQ-015 FSM SHALL have exactly two states: IDLE, SHIFT.
REQ-016 In IDLE, the arbiter SHALL pick the winner combinationally: one valid -> that requester; both valid -> the requester not in last_grant; none -> no grant.
REQ-017 reqN_ready SHALL be high only in IDLE, only for the current winner, and SHALL be combinational from state, valids and last_grant.
REQ-018 A handshake (reqN_valid and reqN_ready high at a posedge) SHALL capture reqN_data into the internal shift register, set last_grant and grant_id to N, clear bit counter to 0, and move to SHIFT.
REQ-019 In SHIFT, sout SHALL equal shift register bit 0 and sout_valid SHALL be 1; each cycle the register SHALL shift right by one with 0 filled at the MSB.
REQ-020 frame_start SHALL be 1 only in the SHIFT cycle with counter = 0.
REQ-021 Counter SHALL increment each SHIFT cycle; at counter = WIDTH-1 the FSM SHALL return to IDLE next cycle, counter cleared.
REQ-022 Latency: handshake at edge t -> bit 0 on sout in cycle t+1, bit WIDTH-1 in cycle t+WIDTH, IDLE in cycle t+WIDTH+1.
REQ-023 Back-to-back: minimum one IDLE cycle between frames; no requester SHALL be accepted during SHIFT.
REQ-024 In IDLE, sout, sout_valid, frame_start SHALL be 0; grant_id SHALL hold its last value.
REQ-025 Requesters hold valid and data stable until ready; data changes while ready is low SHALL have no effect.
REQ-026 Counter width SHALL be ceil(log2(WIDTH)) bits minimum, never exceeding WIDTH-1 in value.
REQ-027 Arbitration is fair: with both requesters continuously valid, grants SHALL strictly alternate.

Reset
REQ-028 rst high at a posedge SHALL force IDLE, counter 0, shift register 0, last_grant 1, grant_id 0, regardless of state.
REQ-029 Reset mid-frame SHALL abort the frame; sout_valid, frame_start, busy SHALL be 0 from the following cycle, remaining bits discarded.
REQ-030 While rst is high, req0_ready and req1_ready SHALL be 0; reset has priority over any handshake at the same edge.

Verification
REQ-031 Reset, then req0_valid=1, req0_data=6'b101101 -> req0_ready=1 that cycle; next six cycles sout=1,0,1,1,0,1, sout_valid=1, frame_start=1 only on first, grant_id=0, busy=1; then IDLE.
REQ-032 Reset, then both valid continuously with req0_data=6'h15, req1_data=6'h2A -> grant order req0, req1, req0, req1; each frame separated by exactly one IDLE cycle.
REQ-033 Only req1_valid held high -> req1 accepted every 7 cycles (WIDTH+1), grant_id=1, no req0_ready.
REQ-034 req1_valid rises during req0 frame -> req1_ready stays 0 until IDLE, then req1 accepted in the first IDLE cycle.
REQ-035 rst asserted during third bit of a frame -> next cycle sout_valid=0, busy=0, frame_start=0; with both valid after release, req0 granted first.
REQ-036 No valid after reset for 20 cycles -> all outputs remain 0, no ready asserted.

Source files
------------

// File: rtl/shift_scheduler_if.sv
// Handshake and serial-output bundle for shift_scheduler: two parallel
// requesters in, one LSB-first serial frame stream out.
interface shift_scheduler_if #(
  parameter int WIDTH = 6
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             grant_id;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, sout, sout_valid, frame_start, grant_id, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, sout, sout_valid, frame_start, grant_id, busy
  );
endinterface

// File: rtl/shift_scheduler.sv
// Two-requester round-robin arbiter feeding a WIDTH-bit parallel-to-serial
// shifter; one frame at a time, at least one IDLE cycle between frames.
module shift_scheduler #(
  parameter int WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  shift_scheduler_if.slave    bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic             last_grant_r;
  logic             grant_id_r;

  logic             win_valid_s;
  logic             win_id_s;
  logic [WIDTH-1:0] win_data_s;
  logic             last_cnt_s;

  assign last_cnt_s = (cnt_r == CW'(WIDTH - 1));

  // Arbiter: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    win_valid_s = 1'b0;
    win_id_s    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      win_valid_s = 1'b1;
      win_id_s    = ~last_grant_r;
    end else if (bus.req0_valid) begin
      win_valid_s = 1'b1;
      win_id_s    = 1'b0;
    end else if (bus.req1_valid) begin
      win_valid_s = 1'b1;
      win_id_s    = 1'b1;
    end else begin
      win_valid_s = 1'b0;
      win_id_s    = 1'b0;
    end
    win_data_s = win_id_s ? bus.req1_data : bus.req0_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_cnt_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath: capture winner word on handshake, then shift one bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r      <= '0;
      cnt_r        <= '0;
      last_grant_r <= 1'b1;
      grant_id_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_valid_s) begin
            shreg_r      <= win_data_s;
            last_grant_r <= win_id_s;
            grant_id_r   <= win_id_s;
            cnt_r        <= '0;
          end else begin
            cnt_r        <= '0;
          end
        end
        SHIFT: begin
          shreg_r <= shreg_r >> 1'b1;
          cnt_r   <= last_cnt_s ? '0 : cnt_r + CW'(1);
        end
        default: begin
          shreg_r <= '0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Outputs; ready is gated by rst so reset always beats a same-edge handshake.
  always_comb begin
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.sout        = 1'b0;
    bus.sout_valid  = 1'b0;
    bus.frame_start = 1'b0;
    bus.busy        = 1'b0;
    bus.grant_id    = grant_id_r;
    case (state_r)
      IDLE: begin
        if (!rst && win_valid_s) begin
          bus.req0_ready = ~win_id_s;
          bus.req1_ready = win_id_s;
        end else begin
          bus.req0_ready = 1'b0;
          bus.req1_ready = 1'b0;
        end
      end
      SHIFT: begin
        bus.sout        = shreg_r[0];
        bus.sout_valid  = 1'b1;
        bus.frame_start = (cnt_r == '0);
        bus.busy        = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end
endmodule
